axi_lite_wdata_fifo: RTL and testbench

Parametrised AXI4-Lite write-data (W) channel buffer. It sits between a W-channel master and a W-channel slave. It accepts beats on a slave-side VALID/READY port and stores WDATA and WSTRB in a DEPTH-entry FIFO. It replays the beats in order on a master-side VALID/READY port, decoupling the two sides and exposing occupancy status.

---
 rtl/axi_lite_pkg.sv | 21 ++
 rtl/axi_lite_fifo_mem.sv | 26 ++
 rtl/axi_lite_wdata_fifo.sv | 101 ++++++++++
 tb/tb_axi_lite_wdata_fifo.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions for the channel buffers: default widths,
// response codes and the W-channel payload layout.
package axi_lite_pkg;

  localparam int unsigned DATA_WIDTH_DEFAULT = 32;

  function automatic int unsigned strb_width(input int unsigned data_width);
    return data_width / 8;
  endfunction

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_t;

  typedef struct packed {
    logic [DATA_WIDTH_DEFAULT-1:0]             data;
    logic [DATA_WIDTH_DEFAULT/8-1:0]           strb;
  } w_payload_t;

endpackage

// File: rtl/axi_lite_fifo_mem.sv
// DEPTH x WIDTH register array: one synchronous write port and one
// combinational read port. Contents are intentionally not reset.
module axi_lite_fifo_mem #(
  parameter int unsigned WIDTH = 36,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/axi_lite_wdata_fifo.sv
// AXI4-Lite W-channel buffer: DEPTH-entry FIFO of {WDATA, WSTRB} with status.
// Optional macro AXI_LITE_WDATA_STRB_MASK_EN zeroes output lanes whose strobe is 0.
module axi_lite_wdata_fifo
  import axi_lite_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int unsigned STRB_WIDTH = strb_width(DATA_WIDTH),
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned CNT_WIDTH  = $clog2(DEPTH) + 1
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  i_FLUSH,
  input  logic                  s_WVALID,
  output logic                  s_WREADY,
  input  logic [DATA_WIDTH-1:0] s_WDATA,
  input  logic [STRB_WIDTH-1:0] s_WSTRB,
  output logic                  m_WVALID,
  input  logic                  m_WREADY,
  output logic [DATA_WIDTH-1:0] m_WDATA,
  output logic [STRB_WIDTH-1:0] m_WSTRB,
  output logic [CNT_WIDTH-1:0]  o_COUNT,
  output logic                  o_FULL,
  output logic                  o_EMPTY
);

  localparam int unsigned AW = CNT_WIDTH - 1;
  localparam int unsigned MW = DATA_WIDTH + STRB_WIDTH;

  logic [CNT_WIDTH-1:0]  wr_ptr, rd_ptr, count;
  logic                  push, pop, full, empty;
  logic [MW-1:0]         rd_word;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [STRB_WIDTH-1:0] rd_strb;

  // MSB of each pointer is the wrap bit; the low bits address storage
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

  assign s_WREADY = !full && !i_FLUSH && !ARESET;
  assign m_WVALID = !empty;
  assign push     = s_WVALID && s_WREADY;
  assign pop      = m_WVALID && m_WREADY;

  assign o_COUNT  = count;
  assign o_FULL   = full;
  assign o_EMPTY  = empty;

  axi_lite_fifo_mem #(
    .WIDTH (MW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (ACLK),
    .we    (push),
    .waddr (wr_ptr[AW-1:0]),
    .wdata ({s_WDATA, s_WSTRB}),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (rd_word)
  );

  assign {rd_data, rd_strb} = rd_word;
  assign m_WSTRB = rd_strb;

  always_comb begin
    m_WDATA = rd_data;
`ifdef AXI_LITE_WDATA_STRB_MASK_EN
    for (int unsigned i = 0; i < STRB_WIDTH; i++) begin
      if (!rd_strb[i]) begin
        m_WDATA[i*8 +: 8] = '0;
      end
    end
`endif
  end

  // Count is kept as its own register rather than derived from the pointers
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (i_FLUSH) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + CNT_WIDTH'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + CNT_WIDTH'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_WIDTH'(1);
        2'b01:   count <= count - CNT_WIDTH'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_wdata_fifo.sv
// Self-checking bench for axi_lite_wdata_fifo: directed vector table, hand
// sequences for streaming and reset, and random traffic against a queue model.
module tb_axi_lite_wdata_fifo;

  localparam int DW    = 32;
  localparam int SW    = 4;
  localparam int DEPTH = 4;
  localparam int CW    = 3;

`ifdef AXI_LITE_WDATA_STRB_MASK_EN
  localparam logic [31:0] M12   = 32'h00005678;
  localparam logic [31:0] MMASK = 32'h00BB00DD;
`else
  localparam logic [31:0] M12   = 32'h12345678;
  localparam logic [31:0] MMASK = 32'hAABBCCDD;
`endif

  logic          ACLK = 1'b0;
  logic          ARESET;
  logic          i_FLUSH;
  logic          s_WVALID;
  logic          s_WREADY;
  logic [DW-1:0] s_WDATA;
  logic [SW-1:0] s_WSTRB;
  logic          m_WVALID;
  logic          m_WREADY;
  logic [DW-1:0] m_WDATA;
  logic [SW-1:0] m_WSTRB;
  logic [CW-1:0] o_COUNT;
  logic          o_FULL;
  logic          o_EMPTY;

  axi_lite_wdata_fifo #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH)
  ) dut (
    .ACLK     (ACLK),
    .ARESET   (ARESET),
    .i_FLUSH  (i_FLUSH),
    .s_WVALID (s_WVALID),
    .s_WREADY (s_WREADY),
    .s_WDATA  (s_WDATA),
    .s_WSTRB  (s_WSTRB),
    .m_WVALID (m_WVALID),
    .m_WREADY (m_WREADY),
    .m_WDATA  (m_WDATA),
    .m_WSTRB  (m_WSTRB),
    .o_COUNT  (o_COUNT),
    .o_FULL   (o_FULL),
    .o_EMPTY  (o_EMPTY)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  strb;
  } beat_t;

  typedef struct {
    logic        vld;
    logic [31:0] d;
    logic [3:0]  s;
    logic        rdy;
    logic        fl;
    int          cnt;
    logic        mv;
    logic [31:0] md;
    logic        sr;
  } vec_t;

  beat_t q[$];
  vec_t  tbl[$];
  int    total = 0;
  int    bad   = 0;

  function automatic vec_t mk(logic vld, logic [31:0] d, logic [3:0] s, logic rdy,
                              logic fl, int cnt, logic mv, logic [31:0] md, logic sr);
    vec_t v;
    v.vld = vld; v.d = d; v.s = s; v.rdy = rdy; v.fl = fl;
    v.cnt = cnt; v.mv = mv; v.md = md; v.sr = sr;
    return v;
  endfunction

  // Expected downstream data for a stored beat
  function automatic logic [31:0] exp_data(logic [31:0] d, logic [3:0] s);
    logic [31:0] r;
    r = d;
`ifdef AXI_LITE_WDATA_STRB_MASK_EN
    for (int i = 0; i < 4; i++) begin
      if (!s[i]) r[i*8 +: 8] = 8'h00;
    end
`endif
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, " count"}, 64'(o_COUNT), 64'(q.size()));
    chk({tag, " m_WVALID"}, 64'(m_WVALID), 64'(q.size() != 0));
    chk({tag, " o_FULL"}, 64'(o_FULL), 64'(q.size() == DEPTH));
    chk({tag, " o_EMPTY"}, 64'(o_EMPTY), 64'(q.size() == 0));
    if (q.size() != 0) begin
      chk({tag, " m_WDATA"}, 64'(m_WDATA), 64'(exp_data(q[0].data, q[0].strb)));
      chk({tag, " m_WSTRB"}, 64'(m_WSTRB), 64'(q[0].strb));
    end
  endtask

  // One clock: drive inputs, check s_WREADY, advance model, check state
  task automatic cycle(input logic vld, input logic [31:0] d, input logic [3:0] s,
                       input logic rdy, input logic fl, input string tag);
    bit do_push, do_pop;
    beat_t b;
    s_WVALID = vld; s_WDATA = d; s_WSTRB = s; m_WREADY = rdy; i_FLUSH = fl;
    #1;
    chk({tag, " s_WREADY"}, 64'(s_WREADY), 64'(q.size() < DEPTH && !fl));
    do_push = vld && (q.size() < DEPTH) && !fl;
    do_pop  = rdy && (q.size() != 0) && !fl;
    b.data = d; b.strb = s;
    @(posedge ACLK);
    if (fl) q.delete();
    else begin
      if (do_pop)  void'(q.pop_front());
      if (do_push) q.push_back(b);
    end
    #1;
    s_WVALID = 1'b0; i_FLUSH = 1'b0;
    #1;
    check_model(tag);
  endtask

  initial begin
    ARESET = 1'b1; i_FLUSH = 1'b0; s_WVALID = 1'b0; s_WDATA = '0; s_WSTRB = '0;
    m_WREADY = 1'b0;
    #12;
    chk("rst m_WVALID", 64'(m_WVALID), 64'(0));
    chk("rst s_WREADY", 64'(s_WREADY), 64'(0));
    chk("rst o_EMPTY", 64'(o_EMPTY), 64'(1));
    chk("rst o_COUNT", 64'(o_COUNT), 64'(0));
    ARESET = 1'b0;
    cycle(1'b0, 32'h0, 4'h0, 1'b0, 1'b0, "idle");
    chk("idle s_WREADY", 64'(s_WREADY), 64'(1));
    chk("idle o_FULL", 64'(o_FULL), 64'(0));

    tbl.push_back(mk(1, 32'hFFFFFFFF, 4'hF, 0, 0, 1, 1, 32'hFFFFFFFF, 1));
    tbl.push_back(mk(1, 32'h12345678, 4'h3, 0, 0, 2, 1, 32'hFFFFFFFF, 1));
    tbl.push_back(mk(0, 32'h0,        4'h0, 1, 0, 1, 1, M12,          1));
    tbl.push_back(mk(0, 32'h0,        4'h0, 1, 0, 0, 0, 32'h0,        1));
    tbl.push_back(mk(1, 32'h1,        4'hF, 0, 0, 1, 1, 32'h1,        1));
    tbl.push_back(mk(1, 32'h2,        4'hF, 0, 0, 2, 1, 32'h1,        1));
    tbl.push_back(mk(1, 32'h3,        4'hF, 0, 0, 3, 1, 32'h1,        1));
    tbl.push_back(mk(1, 32'h4,        4'hF, 0, 0, 4, 1, 32'h1,        0));
    tbl.push_back(mk(1, 32'h5,        4'hF, 0, 0, 4, 1, 32'h1,        0));
    tbl.push_back(mk(0, 32'h0,        4'h0, 1, 0, 3, 1, 32'h2,        1));
    tbl.push_back(mk(0, 32'h0,        4'h0, 1, 0, 2, 1, 32'h3,        1));
    tbl.push_back(mk(0, 32'h0,        4'h0, 1, 0, 1, 1, 32'h4,        1));
    tbl.push_back(mk(0, 32'h0,        4'h0, 1, 0, 0, 0, 32'h0,        1));
    tbl.push_back(mk(1, 32'hA,        4'hF, 0, 0, 1, 1, 32'hA,        1));
    tbl.push_back(mk(1, 32'hB,        4'hF, 0, 0, 2, 1, 32'hA,        1));
    tbl.push_back(mk(1, 32'hC,        4'hF, 0, 0, 3, 1, 32'hA,        1));
    tbl.push_back(mk(1, 32'hD,        4'hF, 0, 1, 0, 0, 32'h0,        1));
    tbl.push_back(mk(0, 32'h0,        4'h0, 1, 0, 0, 0, 32'h0,        1));
    tbl.push_back(mk(1, 32'hAABBCCDD, 4'h5, 0, 0, 1, 1, MMASK,        1));
    tbl.push_back(mk(0, 32'h0,        4'h0, 1, 0, 0, 0, 32'h0,        1));

    foreach (tbl[i]) begin
      cycle(tbl[i].vld, tbl[i].d, tbl[i].s, tbl[i].rdy, tbl[i].fl, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d tbl count", i), 64'(o_COUNT), 64'(tbl[i].cnt));
      chk($sformatf("vec%0d tbl valid", i), 64'(m_WVALID), 64'(tbl[i].mv));
      chk($sformatf("vec%0d tbl ready", i), 64'(s_WREADY), 64'(tbl[i].sr));
      if (tbl[i].mv) chk($sformatf("vec%0d tbl data", i), 64'(m_WDATA), 64'(tbl[i].md));
    end

    // Streaming at count=1: one beat in, one beat out per cycle
    cycle(1'b1, 32'h0, 4'hF, 1'b0, 1'b0, "prime");
    for (int i = 1; i <= 20; i++) begin
      chk($sformatf("stream%0d out", i), 64'(m_WDATA), 64'(i - 1));
      cycle(1'b1, 32'(i), 4'hF, 1'b1, 1'b0, $sformatf("stream%0d", i));
      chk($sformatf("stream%0d count", i), 64'(o_COUNT), 64'(1));
    end
    cycle(1'b0, 32'h0, 4'h0, 1'b1, 1'b0, "drain");

    // Asynchronous reset with beats held
    cycle(1'b1, 32'h77, 4'hF, 1'b0, 1'b0, "pre-rst a");
    cycle(1'b1, 32'h88, 4'hF, 1'b0, 1'b0, "pre-rst b");
    ARESET = 1'b1;
    #1;
    q.delete();
    chk("midrst m_WVALID", 64'(m_WVALID), 64'(0));
    chk("midrst o_COUNT", 64'(o_COUNT), 64'(0));
    chk("midrst s_WREADY", 64'(s_WREADY), 64'(0));
    @(posedge ACLK);
    #1;
    ARESET = 1'b0;
    cycle(1'b0, 32'h0, 4'h0, 1'b1, 1'b0, "postrst");

    // Random traffic against the queue model
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 99) < 60), $urandom, 4'($urandom),
            1'($urandom_range(0, 99) < 50), 1'($urandom_range(0, 31) == 0),
            $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
